// File: rtl/ucode_pkg.sv
// Shared microcode encodings for the sequencer, instruction encoder and control ROM.
package ucode_pkg;

    localparam logic [2:0] NS_DISPATCH = 3'b000;
    localparam logic [2:0] NS_FETCH    = 3'b001;
    localparam logic [2:0] NS_JUMP     = 3'b010;
    localparam logic [2:0] NS_INC      = 3'b011;
    localparam logic [2:0] NS_BRANCH   = 3'b100;
    localparam logic [2:0] NS_WAIT     = 3'b101;
    localparam logic [2:0] NS_CALL     = 3'b110;
    localparam logic [2:0] NS_RET      = 3'b111;

    localparam logic [1:0] CS_MOC  = 2'b00;
    localparam logic [1:0] CS_COND = 2'b01;
    localparam logic [1:0] CS_ONE  = 2'b10;
    localparam logic [1:0] CS_ZERO = 2'b11;

    localparam logic [7:0] FETCH_STATE_DEF = 8'd0;
    localparam logic [7:0] FAULT_STATE_DEF = 8'd1;

endpackage

// File: rtl/ucode_next_addr_mux.sv
// Combinational next-microstate selection and condition test.
module ucode_next_addr_mux
    import ucode_pkg::*;
#(
    parameter int unsigned   SW          = 8,
    parameter logic [SW-1:0] FETCH_STATE = SW'(FETCH_STATE_DEF)
) (
    input  logic [SW-1:0] state,
    input  logic [SW-1:0] ret_reg,
    input  logic [SW-1:0] enc_state,
    input  logic [SW-1:0] cr_addr,
    input  logic [2:0]    nsel,
    input  logic [1:0]    csel,
    input  logic          inv,
    input  logic          moc,
    input  logic          cond,
    output logic [SW-1:0] next_state,
    output logic [SW-1:0] inc,
    output logic          hold
);

    logic sel_test;
    logic t;

    assign inc = state + SW'(1);

    always_comb begin
        sel_test = 1'b0;
        case (csel)
            CS_MOC:  sel_test = moc;
            CS_COND: sel_test = cond;
            CS_ONE:  sel_test = 1'b1;
            CS_ZERO: sel_test = 1'b0;
            default: sel_test = 1'b0;
        endcase
    end

    assign t    = sel_test ^ inv;
    assign hold = (nsel == NS_WAIT) && !t;

    always_comb begin
        next_state = state;
        case (nsel)
            NS_DISPATCH: next_state = enc_state;
            NS_FETCH:    next_state = FETCH_STATE;
            NS_JUMP:     next_state = cr_addr;
            NS_INC:      next_state = inc;
            NS_BRANCH:   next_state = t ? cr_addr : inc;
            NS_WAIT:     next_state = t ? inc : state;
            NS_CALL:     next_state = cr_addr;
            NS_RET:      next_state = ret_reg;
            default:     next_state = state;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: holds the control-ROM address and return register.
// Optional MOC wait timeout enabled by defining MOC_TIMEOUT_EN.
module microsequencer
    import ucode_pkg::*;
#(
    parameter int unsigned   SW          = 8,
    parameter logic [SW-1:0] FETCH_STATE = SW'(FETCH_STATE_DEF),
    parameter logic [SW-1:0] FAULT_STATE = SW'(FAULT_STATE_DEF),
    parameter int unsigned   TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] enc_state,
    input  logic [SW-1:0] cr_addr,
    input  logic [2:0]    nsel,
    input  logic [1:0]    csel,
    input  logic          inv,
    input  logic          moc,
    input  logic          cond,
    output logic [SW-1:0] state,
    output logic          waiting,
    output logic          mem_fault
);

    logic [SW-1:0] ret_reg;
    logic [SW-1:0] next_state;
    logic [SW-1:0] inc;
    logic          hold;

    ucode_next_addr_mux #(
        .SW          (SW),
        .FETCH_STATE (FETCH_STATE)
    ) u_mux (
        .state      (state),
        .ret_reg    (ret_reg),
        .enc_state  (enc_state),
        .cr_addr    (cr_addr),
        .nsel       (nsel),
        .csel       (csel),
        .inv        (inv),
        .moc        (moc),
        .cond       (cond),
        .next_state (next_state),
        .inc        (inc),
        .hold       (hold)
    );

    assign waiting = hold && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_reg <= '0;
        end else if (nsel == NS_CALL) begin
            ret_reg <= inc;
        end
    end

`ifdef MOC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt;
    logic          expire;

    // A satisfied test on the limit cycle drops hold, so it never faults.
    assign expire = hold && (wait_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_STATE;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= expire;
            if (expire) begin
                state    <= FAULT_STATE;
                wait_cnt <= '0;
            end else begin
                state    <= next_state;
                wait_cnt <= hold ? wait_cnt + CW'(1) : '0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH_STATE;
        end else begin
            state <= next_state;
        end
    end

    assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: vector table plus directed corner sequences.
module tb_microsequencer;
    import ucode_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] enc_state;
    logic [7:0] cr_addr;
    logic [2:0] nsel;
    logic [1:0] csel;
    logic       inv;
    logic       moc;
    logic       cond;
    logic [7:0] state;
    logic       waiting;
    logic       mem_fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] nsel;
        logic [1:0] csel;
        logic       inv;
        logic       moc;
        logic       cond;
        logic [7:0] cr;
        logic [7:0] enc;
        logic       ew;
        logic [7:0] es;
    } vec_t;

    typedef struct {
        logic [7:0] st;
        logic       mf;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    microsequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .cr_addr   (cr_addr),
        .nsel      (nsel),
        .csel      (csel),
        .inv       (inv),
        .moc       (moc),
        .cond      (cond),
        .state     (state),
        .waiting   (waiting),
        .mem_fault (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one cycle, check waiting before the edge, score state after it.
    task automatic cyc(input string name, input logic rst,
                       input logic [2:0] ns, input logic [1:0] cs,
                       input logic iv, input logic m, input logic c,
                       input logic [7:0] cr, input logic [7:0] en,
                       input logic ew, input logic [7:0] es,
                       input logic emf);
        exp_t e;
        reset = rst; nsel = ns; csel = cs; inv = iv;
        moc = m; cond = c; cr_addr = cr; enc_state = en;
        #1;
        chk({name, ".waiting"}, int'(waiting), int'(ew));
        e.st = es; e.mf = emf; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".state"}, int'(state), int'(e.st));
        chk({e.name, ".mem_fault"}, int'(mem_fault), int'(e.mf));
        @(negedge clk);
    endtask

    task automatic op(input string name, input logic [2:0] ns,
                      input logic [7:0] cr, input logic [7:0] es);
        cyc(name, 1'b0, ns, CS_ONE, 1'b0, 1'b0, 1'b0, cr, 8'd0,
            1'b0, es, 1'b0);
    endtask

    function automatic vec_t v(input logic [2:0] ns, input logic [1:0] cs,
                               input logic iv, input logic m,
                               input logic c, input logic [7:0] cr,
                               input logic [7:0] en, input logic ew,
                               input logic [7:0] es);
        vec_t r;
        r.nsel = ns; r.csel = cs; r.inv = iv; r.moc = m; r.cond = c;
        r.cr = cr; r.enc = en; r.ew = ew; r.es = es;
        return r;
    endfunction

    initial begin
        reset = 1'b1; nsel = NS_INC; csel = CS_MOC; inv = 1'b0;
        moc = 1'b0; cond = 1'b0; cr_addr = 8'd0; enc_state = 8'd0;

        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd1));
        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd2));
        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd3));
        tbl.push_back(v(NS_FETCH,    CS_ONE,  0, 0, 0, 8'd9,   8'd9, 0, 8'd0));
        tbl.push_back(v(NS_DISPATCH, CS_ONE,  0, 0, 0, 8'd0,   8'd7, 0, 8'd7));
        tbl.push_back(v(NS_JUMP,     CS_ONE,  0, 0, 0, 8'd255, 8'd0, 0, 8'd255));
        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd0));
        tbl.push_back(v(NS_BRANCH,   CS_COND, 0, 0, 1, 8'd40,  8'd0, 0, 8'd40));
        tbl.push_back(v(NS_BRANCH,   CS_COND, 1, 0, 1, 8'd40,  8'd0, 0, 8'd41));
        tbl.push_back(v(NS_BRANCH,   CS_ONE,  0, 0, 0, 8'd40,  8'd0, 0, 8'd40));
        tbl.push_back(v(NS_BRANCH,   CS_ONE,  1, 0, 0, 8'd40,  8'd0, 0, 8'd41));
        tbl.push_back(v(NS_BRANCH,   CS_ZERO, 0, 1, 1, 8'd40,  8'd0, 0, 8'd42));
        tbl.push_back(v(NS_BRANCH,   CS_ZERO, 1, 0, 0, 8'd40,  8'd0, 0, 8'd40));
        tbl.push_back(v(NS_JUMP,     CS_ONE,  0, 0, 0, 8'd20,  8'd0, 0, 8'd20));
        tbl.push_back(v(NS_WAIT,     CS_MOC,  0, 0, 1, 8'd0,   8'd0, 1, 8'd20));
        tbl.push_back(v(NS_WAIT,     CS_MOC,  0, 0, 1, 8'd0,   8'd0, 1, 8'd20));
        tbl.push_back(v(NS_WAIT,     CS_MOC,  0, 0, 1, 8'd0,   8'd0, 1, 8'd20));
        tbl.push_back(v(NS_WAIT,     CS_MOC,  0, 1, 0, 8'd0,   8'd0, 0, 8'd21));
        tbl.push_back(v(NS_WAIT,     CS_MOC,  0, 1, 0, 8'd0,   8'd0, 0, 8'd22));
        tbl.push_back(v(NS_WAIT,     CS_COND, 1, 0, 0, 8'd0,   8'd0, 0, 8'd23));
        tbl.push_back(v(NS_JUMP,     CS_ONE,  0, 0, 0, 8'd30,  8'd0, 0, 8'd30));
        tbl.push_back(v(NS_CALL,     CS_ONE,  0, 0, 0, 8'd90,  8'd0, 0, 8'd90));
        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd91));
        tbl.push_back(v(NS_INC,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd92));
        tbl.push_back(v(NS_RET,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd31));
        tbl.push_back(v(NS_JUMP,     CS_ONE,  0, 0, 0, 8'd100, 8'd0, 0, 8'd100));
        tbl.push_back(v(NS_RET,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd31));
        tbl.push_back(v(NS_CALL,     CS_ONE,  0, 0, 0, 8'd200, 8'd0, 0, 8'd200));
        tbl.push_back(v(NS_CALL,     CS_ONE,  0, 0, 0, 8'd10,  8'd0, 0, 8'd10));
        tbl.push_back(v(NS_RET,      CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd201));
        tbl.push_back(v(NS_DISPATCH, CS_ONE,  0, 0, 0, 8'd0,   8'd0, 0, 8'd0));

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cyc("reset", 1'b1, 3'($urandom_range(7)), 2'($urandom_range(3)),
                1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 8'($urandom), 8'($urandom),
                1'b0, 8'd0, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), 1'b0, tbl[i].nsel, tbl[i].csel,
                tbl[i].inv, tbl[i].moc, tbl[i].cond, tbl[i].cr,
                tbl[i].enc, tbl[i].ew, tbl[i].es, 1'b0);
        end

        // Reset in the middle of a call sequence clears ret_reg.
        op("rc_jump", NS_JUMP, 8'd30, 8'd30);
        op("rc_call", NS_CALL, 8'd90, 8'd90);
        op("rc_inc",  NS_INC,  8'd0,  8'd91);
        cyc("rc_reset", 1'b1, NS_INC, CS_ONE, 1'b0, 1'b0, 1'b0,
            8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        op("rc_ret",  NS_RET,  8'd0,  8'd0);

        // Reset mid-wait abandons the wait.
        op("rw_jump", NS_JUMP, 8'd20, 8'd20);
        cyc("rw_wait", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
            8'd0, 8'd0, 1'b1, 8'd20, 1'b0);
        cyc("rw_reset", 1'b1, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
            8'd0, 8'd0, 1'b0, 8'd0, 1'b0);

`ifdef MOC_TIMEOUT_EN
        op("to_jump", NS_JUMP, 8'd20, 8'd20);
        for (int i = 0; i < 15; i++)
            cyc("to_hold", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
                8'd0, 8'd0, 1'b1, 8'd20, 1'b0);
        cyc("to_fault", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
            8'd0, 8'd0, 1'b1, 8'd1, 1'b1);
        op("to_after", NS_INC, 8'd0, 8'd2);

        op("tl_jump", NS_JUMP, 8'd20, 8'd20);
        for (int i = 0; i < 15; i++)
            cyc("tl_hold", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
                8'd0, 8'd0, 1'b1, 8'd20, 1'b0);
        cyc("tl_moc", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b1, 1'b0,
            8'd0, 8'd0, 1'b0, 8'd21, 1'b0);
        for (int i = 0; i < 15; i++)
            cyc("tl_clr", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
                8'd0, 8'd0, 1'b1, 8'd21, 1'b0);
        cyc("tl_fault2", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
            8'd0, 8'd0, 1'b1, 8'd1, 1'b1);
`else
        op("nt_jump", NS_JUMP, 8'd20, 8'd20);
        for (int i = 0; i < 20; i++)
            cyc("nt_hold", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b0, 1'b0,
                8'd0, 8'd0, 1'b1, 8'd20, 1'b0);
        cyc("nt_moc", 1'b0, NS_WAIT, CS_MOC, 1'b0, 1'b1, 1'b0,
            8'd0, 8'd0, 1'b0, 8'd21, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
